// File: rtl/scan_arbiter_pkg.sv
// Shared types and defaults for the two-requester address-sweep arbiter.
package scan_arbiter_pkg;

  localparam int SIZE_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Winner index; on a tie the requester not served last wins.
  function automatic logic rr_pick(
    input logic [1:0] req,
    input logic       last_w
  );
    if (req == 2'b11) return ~last_w;
    return req[1];
  endfunction

endpackage

// File: rtl/scan_arbiter_if.sv
// Request/burst bus between requesters and the address engine.
interface scan_arbiter_if #(
  parameter int SIZE = scan_arbiter_pkg::SIZE_DEF
);

  logic [1:0]      req;
  logic [SIZE-1:0] base0;
  logic [SIZE-1:0] base1;
  logic [SIZE-1:0] len0;
  logic [SIZE-1:0] len1;
  logic            hold;
  logic [1:0]      grant;
  logic [SIZE-1:0] addr;
  logic            addr_vld;
  logic            last;
  logic            done;
  logic            busy;

  modport master (
    output req, base0, base1,
    output len0, len1, hold,
    input  grant, addr, addr_vld,
    input  last, done, busy
  );

  modport slave (
    input  req, base0, base1,
    input  len0, len1, hold,
    output grant, addr, addr_vld,
    output last, done, busy
  );

endinterface

// File: rtl/scan_addr_cnt.sv
// Loadable wrapping up-counter used for burst address and offset.
module scan_addr_cnt
  import scan_arbiter_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [SIZE-1:0] val_i,
  output logic [SIZE-1:0] cnt_o
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  logic [SIZE-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = val_i;
    else if (inc_i) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/scan_arbiter.sv
// Round-robin arbiter that grants one requester an address burst sweep.
module scan_arbiter
  import scan_arbiter_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  scan_arbiter_if.slave bus
);

  localparam logic [SIZE-1:0] ZERO = '0;
  localparam logic [SIZE-1:0] ONE  = SIZE'(1);

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [SIZE-1:0] len_q, len_d;
  logic            vld_q, vld_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            ptr_q, ptr_d;

  logic            win;
  logic            ld, inc;
  logic [SIZE-1:0] ld_base, len_sel;
  logic [SIZE-1:0] addr, cnt;

  scan_addr_cnt #(.SIZE(SIZE)) u_addr (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld),
    .inc_i  (inc),
    .val_i  (ld_base),
    .cnt_o  (addr)
  );

  scan_addr_cnt #(.SIZE(SIZE)) u_off (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld),
    .inc_i  (inc),
    .val_i  (ZERO),
    .cnt_o  (cnt)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    len_d   = len_q;
    vld_d   = 1'b0;
    last_d  = last_q;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    ld      = 1'b0;
    inc     = 1'b0;
    win     = rr_pick(bus.req, ptr_q);
    ld_base = win ? bus.base1 : bus.base0;
    len_sel = win ? bus.len1 : bus.len0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = BURST;
          grant_d = win ? 2'b10 : 2'b01;
          len_d   = len_sel;
          ld      = 1'b1;
          vld_d   = 1'b1;
          last_d  = (len_sel == ZERO);
        end
      end
      BURST: begin
        // A stall freezes everything; the shown address was consumed.
        if (!bus.hold) begin
          if (last_q) begin
            state_d = DONE;
            grant_d = 2'b00;
            last_d  = 1'b0;
            done_d  = 1'b1;
            ptr_d   = grant_q[1];
          end else begin
            inc    = 1'b1;
            vld_d  = 1'b1;
            last_d = (cnt + ONE == len_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      len_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.addr     = addr;
  assign bus.addr_vld = vld_q;
  assign bus.last     = last_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_scan_arbiter.sv
// Bench for scan_arbiter: vector table, corner sequences, random vs model.
module tb_scan_arbiter;
  import scan_arbiter_pkg::*;

  localparam int SIZE = 3;
  localparam int NA   = 1 << SIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  scan_arbiter_if #(.SIZE(SIZE)) bus ();

  scan_arbiter #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [1:0] r,
    input logic [2:0] b0, l0, b1, l1,
    input logic       h
  );
    bus.req   = r;
    bus.base0 = b0;
    bus.len0  = l0;
    bus.base1 = b1;
    bus.len1  = l1;
    bus.hold  = h;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus.busy; i++) tick();
    chk("idle_wait", int'(bus.busy), 0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_grant"}, int'(bus.grant), 0);
    chk({nm, "_addr"}, int'(bus.addr), 0);
    chk({nm, "_vld"}, int'(bus.addr_vld), 0);
    chk({nm, "_last"}, int'(bus.last), 0);
    chk({nm, "_done"}, int'(bus.done), 0);
    chk({nm, "_busy"}, int'(bus.busy), 0);
  endtask

  // Reference: a timeline of planned cycles per burst.
  // >=0 address, -1 done cycle, -2 idle gap cycle.
  int tl[$];
  int cur;
  int lw;
  int owner;
  int eaddr;
  bit stall;

  task automatic mdl_reset();
    tl.delete();
    cur   = -3;
    lw    = 1;
    owner = 0;
    eaddr = 0;
    stall = 0;
  endtask

  task automatic mdl_step(
    input  int r, b0, l0, b1, l1, h,
    output int exp
  );
    int w, b, l, g, vl, ls, dn, bs;
    if (cur >= 0 && h != 0) begin
      stall = 1;
    end else begin
      stall = 0;
      if (tl.size() == 0) begin
        if (r != 0) begin
          if (r == 3) w = (lw == 0) ? 1 : 0;
          else        w = (r == 2) ? 1 : 0;
          owner = w;
          b = w ? b1 : b0;
          l = w ? l1 : l0;
          for (int i = 0; i <= l; i++)
            tl.push_back((b + i) % NA);
          tl.push_back(-1);
          tl.push_back(-2);
          cur = tl.pop_front();
        end else begin
          cur = -3;
        end
      end else begin
        cur = tl.pop_front();
        if (cur == -1) lw = owner;
      end
    end
    if (cur >= 0) eaddr = cur;
    g = 0; vl = 0; ls = 0; dn = 0; bs = 0;
    if (cur >= 0) begin
      g  = owner ? 2 : 1;
      vl = stall ? 0 : 1;
      ls = (tl[0] == -1) ? 1 : 0;
      bs = 1;
    end else if (cur == -1) begin
      dn = 1;
      bs = 1;
    end
    exp = (g << 7) | (eaddr << 4) | (vl << 3);
    exp = exp | (ls << 2) | (dn << 1) | bs;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [2:0] b0, l0, b1, l1;
    logic [1:0] g;
    logic [2:0] a0;
    int         n;
    logic [2:0] al;
  } vec_t;

  vec_t tv[6];

  initial begin
    logic [2:0] a;
    int nv;
    int exp, got;

    tv[0] = '{2'b01, 3'd2, 3'd3, 3'd0, 3'd0, 2'b01, 3'd2, 4, 3'd5};
    tv[1] = '{2'b10, 3'd0, 3'd0, 3'd6, 3'd3, 2'b10, 3'd6, 4, 3'd1};
    tv[2] = '{2'b11, 3'd5, 3'd1, 3'd3, 3'd2, 2'b01, 3'd5, 2, 3'd6};
    tv[3] = '{2'b11, 3'd0, 3'd0, 3'd7, 3'd0, 2'b10, 3'd7, 1, 3'd7};
    tv[4] = '{2'b10, 3'd0, 3'd0, 3'd4, 3'd7, 2'b10, 3'd4, 8, 3'd3};
    tv[5] = '{2'b11, 3'd1, 3'd2, 3'd0, 3'd0, 2'b01, 3'd1, 3, 3'd3};

    drive(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    #1 rst = 1'b0;
    #12;
    chk_zero("reset");
    tick();
    rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      wait_idle();
      drive(tv[v].req, tv[v].b0, tv[v].l0,
            tv[v].b1, tv[v].l1, 1'b0);
      tick();
      bus.req = 2'b00;
      a = tv[v].a0;
      for (int i = 0; i < tv[v].n; i++) begin
        chk("tv_grant", int'(bus.grant), int'(tv[v].g));
        chk("tv_addr", int'(bus.addr), int'(a));
        chk("tv_vld", int'(bus.addr_vld), 1);
        chk("tv_last", int'(bus.last),
            (i == tv[v].n - 1) ? 1 : 0);
        chk("tv_busy", int'(bus.busy), 1);
        if (i == tv[v].n - 1)
          chk("tv_end_addr", int'(bus.addr), int'(tv[v].al));
        a = a + 3'd1;
        tick();
      end
      chk("tv_done", int'(bus.done), 1);
      chk("tv_done_grant", int'(bus.grant), 0);
      chk("tv_done_vld", int'(bus.addr_vld), 0);
      chk("tv_done_busy", int'(bus.busy), 1);
      tick();
      chk("tv_idle_done", int'(bus.done), 0);
      chk("tv_idle_busy", int'(bus.busy), 0);
      chk("tv_idle_addr", int'(bus.addr), int'(tv[v].al));
    end

    // Stall for three cycles on the second valid address.
    wait_idle();
    drive(2'b01, 3'd0, 3'd2, 3'd0, 3'd0, 1'b0);
    nv = 0;
    tick();
    bus.req = 2'b00;
    chk("st_a0", int'(bus.addr), 0);
    nv += int'(bus.addr_vld);
    tick();
    chk("st_a1", int'(bus.addr), 1);
    nv += int'(bus.addr_vld);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_vld", int'(bus.addr_vld), 0);
      chk("st_hold_addr", int'(bus.addr), 1);
      chk("st_hold_grant", int'(bus.grant), 1);
      chk("st_hold_last", int'(bus.last), 0);
      nv += int'(bus.addr_vld);
    end
    bus.hold = 1'b0;
    tick();
    chk("st_a2", int'(bus.addr), 2);
    chk("st_a2_last", int'(bus.last), 1);
    nv += int'(bus.addr_vld);
    tick();
    chk("st_done", int'(bus.done), 1);
    chk("st_nvalid", nv, 3);
    tick();

    // Inputs changed mid-burst are ignored.
    wait_idle();
    drive(2'b01, 3'd4, 3'd2, 3'd0, 3'd0, 1'b0);
    tick();
    drive(2'b00, 3'd0, 3'd7, 3'd1, 3'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("mb_addr", int'(bus.addr), 4 + i);
      chk("mb_vld", int'(bus.addr_vld), 1);
      chk("mb_last", int'(bus.last), (i == 2) ? 1 : 0);
      tick();
    end
    chk("mb_done", int'(bus.done), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mb_no_grant", int'(bus.grant), 0);
      chk("mb_idle", int'(bus.busy), 0);
    end

    // Asynchronous reset mid-burst, then round-robin from reset.
    wait_idle();
    drive(2'b10, 3'd0, 3'd0, 3'd0, 3'd7, 1'b0);
    tick();
    bus.req = 2'b00;
    tick();
    #2 rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    drive(2'b11, 3'd3, 3'd0, 3'd5, 3'd0, 1'b0);
    tick();
    chk("rst_no_done", int'(bus.done), 0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant", int'(bus.grant), (k % 2) ? 2 : 1);
      chk("rr_addr", int'(bus.addr), (k % 2) ? 5 : 3);
      chk("rr_last", int'(bus.last), 1);
      tick();
      chk("rr_done", int'(bus.done), 1);
      chk("rr_done_grant", int'(bus.grant), 0);
      tick();
      chk("rr_idle_grant", int'(bus.grant), 0);
    end

    // Random stimulus against the timeline model.
    drive(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    #2 rst = 1'b0;
    tick();
    rst = 1'b1;
    mdl_reset();
    for (int c = 0; c < 800; c++) begin
      tick();
      mdl_step(int'(bus.req), int'(bus.base0), int'(bus.len0),
               int'(bus.base1), int'(bus.len1), int'(bus.hold),
               exp);
      got = int'({bus.grant, bus.addr, bus.addr_vld,
                  bus.last, bus.done, bus.busy});
      chk("rand_outputs", got, exp);
      bus.req   = 2'($urandom_range(0, 3));
      bus.base0 = 3'($urandom_range(0, NA - 1));
      bus.base1 = 3'($urandom_range(0, NA - 1));
      bus.len0  = 3'($urandom_range(0, NA - 1));
      bus.len1  = 3'($urandom_range(0, NA - 1));
      bus.hold  = ($urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
